// File: rtl/ex_stage_muldiv.sv
// Execute stage with EX/MEM pipeline register and an iterative multiply/divide
// unit that owns HI/LO and stalls upstream stages while it iterates.
module ex_stage_muldiv #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      EX_ALUOp,
    input  logic [XLEN-1:0] EX_D1,
    input  logic [XLEN-1:0] EX_D2,
    input  logic [XLEN-1:0] EX_imm,
    input  logic [4:0]      EX_shamt,
    input  logic [4:0]      EX_RD,
    input  logic [4:0]      EX_RT,
    input  logic            EX_RegDst,
    input  logic            EX_ALUSrc,
    input  logic            EX_shift,
    input  logic [1:0]      EX_hilo_sel,
    input  logic            EX_RegWrite,
    input  logic            EX_MemToReg,
    input  logic            EX_MEM_WEN,
    input  logic            EX_MEM_REN,
    output logic [XLEN-1:0] MEM_ALU_result,
    output logic [XLEN-1:0] MEM_store_data,
    output logic [4:0]      MEM_write_reg,
    output logic            MEM_RegWrite,
    output logic            MEM_MemToReg,
    output logic            MEM_MEM_WEN,
    output logic            MEM_MEM_REN,
    output logic            stall
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_dividend;
    logic [2*XLEN-1:0] r_acc;
    logic              r_is_div, r_neg_q, r_neg_r, r_dz;

    logic [XLEN-1:0]   w_b, w_alu, w_result;
    logic [4:0]        w_sa;
    logic              w_is_md, w_signed_md, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_mul_sum, w_rem_sh;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_hi_new, w_lo_new;

    assign w_b         = EX_ALUSrc ? EX_imm : EX_D2;
    assign w_sa        = EX_shift ? EX_shamt : EX_D1[4:0];
    assign w_is_md     = (EX_ALUOp[3:2] == 2'b11);
    assign w_signed_md = w_is_md & ~EX_ALUOp[0];
    assign w_a_neg     = w_signed_md & EX_D1[XLEN-1];
    assign w_b_neg     = w_signed_md & w_b[XLEN-1];
    assign w_a_mag     = w_a_neg ? (~EX_D1 + 1'b1) : EX_D1;
    assign w_b_mag     = w_b_neg ? (~w_b + 1'b1) : w_b;

    // Stall is gated by reset so an aborted operation releases upstream at once.
    assign stall = ~reset & (((r_state == S_IDLE) & w_is_md) | (r_state == S_BUSY));

    always_comb begin
        w_alu = '0;
        case (EX_ALUOp)
            4'd0:    w_alu = EX_D1 + w_b;
            4'd1:    w_alu = EX_D1 - w_b;
            4'd2:    w_alu = EX_D1 & w_b;
            4'd3:    w_alu = EX_D1 | w_b;
            4'd4:    w_alu = EX_D1 ^ w_b;
            4'd5:    w_alu = ~(EX_D1 | w_b);
            4'd6:    w_alu = {{(XLEN-1){1'b0}}, ($signed(EX_D1) < $signed(w_b))};
            4'd7:    w_alu = {{(XLEN-1){1'b0}}, (EX_D1 < w_b)};
            4'd8:    w_alu = EX_D2 << w_sa;
            4'd9:    w_alu = EX_D2 >> w_sa;
            4'd10:   w_alu = $signed(EX_D2) >>> w_sa;
            4'd11:   w_alu = {w_b[15:0], 16'h0000};
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_result = w_alu;
        case (EX_hilo_sel)
            2'b01:   w_result = r_hi;
            2'b10:   w_result = r_lo;
            default: w_result = w_alu;
        endcase
    end

    // One iteration: shift-add multiply on {HI,LO}, or restoring divide where
    // the upper half holds the partial remainder and the lower half the quotient.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff     = w_rem_sh[XLEN-1:0] - r_opnd;
        w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        if (r_is_div) begin
            if (w_rem_sh >= {1'b0, r_opnd})
                w_acc_next = {w_diff, r_acc[XLEN-2:0], 1'b1};
            else
                w_acc_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end
    end

    assign w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo    = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem    = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    assign w_hi_new = r_is_div ? (r_dz ? r_dividend : w_rem) : w_prod[2*XLEN-1:XLEN];
    assign w_lo_new = r_is_div ? (r_dz ? '1 : w_quo) : w_prod[XLEN-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_acc      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_md) begin
                        r_state    <= S_BUSY;
                        r_cnt      <= '0;
                        r_is_div   <= EX_ALUOp[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_dz       <= EX_ALUOp[1] & (w_b == '0);
                        r_dividend <= EX_D1;
                        r_acc      <= {{XLEN{1'b0}}, (EX_ALUOp[1] ? w_a_mag : w_b_mag)};
                        r_opnd     <= EX_ALUOp[1] ? w_b_mag : w_a_mag;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(MD_CYCLES - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_hi    <= w_hi_new;
                    r_lo    <= w_lo_new;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MEM_ALU_result <= '0;
            MEM_store_data <= '0;
            MEM_write_reg  <= '0;
            MEM_RegWrite   <= 1'b0;
            MEM_MemToReg   <= 1'b0;
            MEM_MEM_WEN    <= 1'b0;
            MEM_MEM_REN    <= 1'b0;
        end else if (stall) begin
            MEM_RegWrite   <= 1'b0;
            MEM_MemToReg   <= 1'b0;
            MEM_MEM_WEN    <= 1'b0;
            MEM_MEM_REN    <= 1'b0;
        end else begin
            MEM_ALU_result <= w_result;
            MEM_store_data <= EX_D2;
            MEM_write_reg  <= EX_RegDst ? EX_RD : EX_RT;
            MEM_RegWrite   <= EX_RegWrite;
            MEM_MemToReg   <= EX_MemToReg;
            MEM_MEM_WEN    <= EX_MEM_WEN;
            MEM_MEM_REN    <= EX_MEM_REN;
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv: ALU ops, pipeline timing, mul/div results,
// stall length, bubble insertion and mid-operation reset.
module tb_ex_stage_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  EX_ALUOp;
    logic [31:0] EX_D1, EX_D2, EX_imm;
    logic [4:0]  EX_shamt, EX_RD, EX_RT;
    logic        EX_RegDst, EX_ALUSrc, EX_shift;
    logic [1:0]  EX_hilo_sel;
    logic        EX_RegWrite, EX_MemToReg, EX_MEM_WEN, EX_MEM_REN;
    logic [31:0] MEM_ALU_result, MEM_store_data;
    logic [4:0]  MEM_write_reg;
    logic        MEM_RegWrite, MEM_MemToReg, MEM_MEM_WEN, MEM_MEM_REN;
    logic        stall;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int bubble_bad;
    logic [31:0] val;

    ex_stage_muldiv #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clock(clock), .reset(reset),
        .EX_ALUOp(EX_ALUOp), .EX_D1(EX_D1), .EX_D2(EX_D2), .EX_imm(EX_imm),
        .EX_shamt(EX_shamt), .EX_RD(EX_RD), .EX_RT(EX_RT),
        .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_shift(EX_shift),
        .EX_hilo_sel(EX_hilo_sel),
        .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
        .EX_MEM_WEN(EX_MEM_WEN), .EX_MEM_REN(EX_MEM_REN),
        .MEM_ALU_result(MEM_ALU_result), .MEM_store_data(MEM_store_data),
        .MEM_write_reg(MEM_write_reg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg),
        .MEM_MEM_WEN(MEM_MEM_WEN), .MEM_MEM_REN(MEM_MEM_REN),
        .stall(stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
            $error("miscompare in %s", tag);
        end
    endtask

    function automatic logic [31:0] ctrl();
        return {28'h0, MEM_RegWrite, MEM_MemToReg, MEM_MEM_WEN, MEM_MEM_REN};
    endfunction

    task automatic idle_inputs();
        EX_ALUOp = 4'd0; EX_D1 = '0; EX_D2 = '0; EX_imm = '0; EX_shamt = '0;
        EX_RD = '0; EX_RT = '0; EX_RegDst = 0; EX_ALUSrc = 0; EX_shift = 0;
        EX_hilo_sel = 2'b00; EX_RegWrite = 0; EX_MemToReg = 0; EX_MEM_WEN = 0; EX_MEM_REN = 0;
    endtask

    // Issue a mul/div at a negedge, count stalled cycles, leave it through the DONE edge.
    task automatic md_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output int n_bad);
        idle_inputs();
        EX_ALUOp = op; EX_D1 = a; EX_D2 = b; EX_MEM_REN = 1; EX_MemToReg = 1;
        #1;
        n_stall = 0; n_bad = 0;
        while (stall && n_stall < 100) begin
            @(negedge clock);
            n_stall++;
            if (ctrl() != 32'h0) n_bad++;
        end
        @(negedge clock);
        idle_inputs();
    endtask

    task automatic read_hilo(input logic [1:0] sel, output logic [31:0] v);
        idle_inputs();
        EX_hilo_sel = sel;
        @(negedge clock);
        v = MEM_ALU_result;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clock);
        check("rst_result", MEM_ALU_result, 32'h0);
        check("rst_ctrl", ctrl(), 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        reset = 0;

        // ADD with sign-extended immediate, writes rt
        EX_ALUOp = 4'd0; EX_D1 = 32'd5; EX_imm = 32'hFFFF_FFFD; EX_ALUSrc = 1;
        EX_RegDst = 0; EX_RT = 5'd9; EX_RD = 5'd3; EX_D2 = 32'h1234_5678;
        EX_RegWrite = 1; EX_MemToReg = 1; EX_MEM_WEN = 0; EX_MEM_REN = 1;
        @(negedge clock);
        check("add_result", MEM_ALU_result, 32'd2);
        check("add_wreg", {27'h0, MEM_write_reg}, 32'd9);
        check("add_ctrl", ctrl(), 32'b1101);
        check("add_store", MEM_store_data, 32'h1234_5678);

        idle_inputs();
        EX_ALUOp = 4'd6; EX_D1 = 32'hFFFF_FFFF; EX_D2 = 32'd1; EX_RegDst = 1; EX_RD = 5'd17;
        @(negedge clock);
        check("slt", MEM_ALU_result, 32'd1);
        check("rd_wreg", {27'h0, MEM_write_reg}, 32'd17);
        EX_ALUOp = 4'd7;
        @(negedge clock);
        check("sltu", MEM_ALU_result, 32'd0);

        idle_inputs();
        EX_ALUOp = 4'd10; EX_D2 = 32'h8000_0000; EX_shamt = 5'd4; EX_shift = 1;
        @(negedge clock);
        check("sra", MEM_ALU_result, 32'hF800_0000);
        EX_ALUOp = 4'd9; EX_shift = 0; EX_D1 = 32'h0000_0008; EX_D2 = 32'hF000_0000;
        @(negedge clock);
        check("srlv", MEM_ALU_result, 32'h00F0_0000);
        EX_ALUOp = 4'd11; EX_ALUSrc = 1; EX_imm = 32'h0000_ABCD;
        @(negedge clock);
        check("lui", MEM_ALU_result, 32'hABCD_0000);
        EX_ALUOp = 4'd5; EX_ALUSrc = 0; EX_D1 = 32'h0F0F_0000; EX_D2 = 32'h0000_00FF;
        @(negedge clock);
        check("nor", MEM_ALU_result, 32'hF0F0_FF00);

        // MULT -3 * 7, then immediate MFLO / MFHI
        md_op(4'd12, 32'hFFFF_FFFD, 32'd7, cyc, bubble_bad);
        check("mult_stall_cycles", cyc, 32'd33);
        check("mult_bubbles", bubble_bad, 32'd0);
        check("mult_passthru_ctrl", ctrl(), 32'b0101);
        read_hilo(2'b10, val); check("mult_lo", val, 32'hFFFF_FFEB);
        read_hilo(2'b01, val); check("mult_hi", val, 32'hFFFF_FFFF);

        md_op(4'd14, 32'hFFFF_FFF9, 32'd2, cyc, bubble_bad);
        read_hilo(2'b10, val); check("div_lo", val, 32'hFFFF_FFFD);
        read_hilo(2'b01, val); check("div_hi", val, 32'hFFFF_FFFF);

        md_op(4'd15, 32'd10, 32'd0, cyc, bubble_bad);
        check("divu_stall_cycles", cyc, 32'd33);
        read_hilo(2'b10, val); check("divu0_lo", val, 32'hFFFF_FFFF);
        read_hilo(2'b01, val); check("divu0_hi", val, 32'd10);

        md_op(4'd14, 32'hFFFF_FFFB, 32'd0, cyc, bubble_bad);
        read_hilo(2'b10, val); check("div0_lo", val, 32'hFFFF_FFFF);
        read_hilo(2'b01, val); check("div0_hi", val, 32'hFFFF_FFFB);

        md_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bubble_bad);
        read_hilo(2'b10, val); check("multu_lo", val, 32'h0000_0001);
        read_hilo(2'b01, val); check("multu_hi", val, 32'hFFFF_FFFE);

        md_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bubble_bad);
        read_hilo(2'b10, val); check("divovf_lo", val, 32'h8000_0000);
        read_hilo(2'b01, val); check("divovf_hi", val, 32'h0);

        md_op(4'd15, 32'd100, 32'd7, cyc, bubble_bad);
        read_hilo(2'b10, val); check("divu_lo", val, 32'd14);
        read_hilo(2'b01, val); check("divu_hi", val, 32'd2);

        // Reset during BUSY cycle 10 of a MULT
        idle_inputs();
        EX_ALUOp = 4'd12; EX_D1 = 32'd1234; EX_D2 = 32'd5678; EX_RegWrite = 1;
        repeat (11) @(negedge clock);
        check("pre_reset_stall", {31'h0, stall}, 32'd1);
        reset = 1;
        idle_inputs();
        #1;
        check("reset_stall", {31'h0, stall}, 32'd0);
        check("reset_ctrl", ctrl(), 32'h0);
        check("reset_result", MEM_ALU_result, 32'h0);
        @(negedge clock);
        reset = 0;
        read_hilo(2'b10, val); check("reset_lo", val, 32'h0);
        read_hilo(2'b01, val); check("reset_hi", val, 32'h0);
        EX_ALUOp = 4'd0; EX_D1 = 32'd1; EX_D2 = 32'd2; EX_RegWrite = 1; EX_RT = 5'd4;
        @(negedge clock);
        check("post_reset_add", MEM_ALU_result, 32'd3);
        check("post_reset_ctrl", ctrl(), 32'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
